// File: rtl/seg_display_arbiter.sv
// Round-robin time-sharing of one 7-segment display among four requesters.
// Each grant holds for DWELL enabled cycles, and the granted nibble is decoded to a hex glyph.
module seg_display_arbiter #(
    parameter int DWELL = 1000,
    parameter int CNT_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  req,
    input  logic [15:0] val,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic [6:0]  seg,
    output logic        busy
);

    typedef enum logic {IDLE, SHOW} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    state_t           state, state_n;
    logic [1:0]       ptr, ptr_n, cur, cur_n;
    logic [1:0]       base, cand, win;
    logic             found, rearb;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       gnt_n, done_n;
    logic [6:0]       seg_n;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h3F;
            4'h1: decode = 7'h06;
            4'h2: decode = 7'h5B;
            4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;
            4'h5: decode = 7'h6D;
            4'h6: decode = 7'h7D;
            4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h6F;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;
            4'hD: decode = 7'h5E;
            4'hE: decode = 7'h79;
            default: decode = 7'h71;
        endcase
    endfunction

    function automatic logic [3:0] nibble(input logic [15:0] v, input logic [1:0] idx);
        nibble = v[{idx, 2'b00} +: 4];
    endfunction

    // While showing, the current holder acts as the pointer, so it is searched last
    always_comb begin
        base  = (state == SHOW) ? cur : ptr;
        found = 1'b0;
        win   = base;
        cand  = base;
        for (int i = 1; i <= 4; i++) begin
            cand = base + 2'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        seg_n   = seg;
        cnt_n   = cnt;
        ptr_n   = ptr;
        cur_n   = cur;
        done_n  = '0;
        rearb   = 1'b0;
        if (en) begin
            case (state)
                IDLE: rearb = 1'b1;
                SHOW: begin
                    if (cnt == LAST || !req[cur]) begin
                        done_n[cur] = (cnt == LAST);
                        ptr_n       = cur;
                        rearb       = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                        seg_n = decode(nibble(val, cur));
                    end
                end
            endcase
            if (rearb) begin
                cnt_n = '0;
                if (found) begin
                    state_n = SHOW;
                    gnt_n   = 4'b0001 << win;
                    seg_n   = decode(nibble(val, win));
                    cur_n   = win;
                end else begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    seg_n   = '0;
                end
            end
        end
    end

    // ptr resets to 3 so requester 0 wins the first arbitration
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            done  <= '0;
            seg   <= '0;
            cnt   <= '0;
            ptr   <= 2'd3;
            cur   <= 2'd0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            done  <= done_n;
            seg   <= seg_n;
            cnt   <= cnt_n;
            ptr   <= ptr_n;
            cur   <= cur_n;
        end
    end

    assign busy = |gnt;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Vector table and scoreboard bench for seg_display_arbiter (DWELL=4), plus a DWELL=1 rotation sequence.
module tb_seg_display_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  req = 4'h0;
    logic [15:0] val = 16'h0;
    logic [3:0]  gnt, done, gnt1, done1;
    logic [6:0]  seg, seg1;
    logic        busy, busy1;

    always #5 clk = ~clk;

    seg_display_arbiter #(.DWELL(4), .CNT_W(10)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .val(val),
        .gnt(gnt), .done(done), .seg(seg), .busy(busy)
    );

    seg_display_arbiter #(.DWELL(1), .CNT_W(10)) dut1 (
        .clk(clk), .rst(rst), .en(en), .req(req), .val(val),
        .gnt(gnt1), .done(done1), .seg(seg1), .busy(busy1)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        en;
        logic [3:0]  req;
        logic [15:0] val;
        logic [3:0]  gnt;
        logic [3:0]  done;
        logic [6:0]  seg;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] gnt;
        logic [3:0] done;
        logic [6:0] seg;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic add(input string n, input logic r, input logic e, input logic [3:0] q,
                       input logic [15:0] v, input logic [3:0] g, input logic [3:0] d,
                       input logic [6:0] s, input int reps = 1);
        for (int k = 0; k < reps; k++) vecs.push_back('{n, r, e, q, v, g, d, s});
    endtask

    task automatic checkOutput(input int idx);
        exp_t x;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_empty row %0d: got gnt=%b, want an expected entry", idx, gnt);
        end else begin
            x = sb.pop_front();
            if ({gnt, done, seg, busy} !== {x.gnt, x.done, x.seg, |x.gnt}) begin
                bad++;
                $display("[TB] FAIL %s row %0d: got gnt=%b done=%b seg=%h busy=%b, want gnt=%b done=%b seg=%h busy=%b",
                         x.name, idx, gnt, done, seg, busy, x.gnt, x.done, x.seg, |x.gnt);
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        rst = v.rst;
        en  = v.en;
        req = v.req;
        val = v.val;
        sb.push_back('{v.name, v.gnt, v.done, v.seg});
        @(posedge clk);
        #1;
        checkOutput(idx);
    endtask

    initial begin
        logic [3:0]  eg, ed;
        logic [6:0]  es;
        logic [15:0] pat;

        add("reset",    1, 1, 4'hF, 16'h0000, 4'h0, 4'h0, 7'h00);
        add("reset_en0",1, 0, 4'hF, 16'h0000, 4'h0, 4'h0, 7'h00);

        add("single", 0, 1, 4'h1, 16'h0005, 4'h1, 4'h0, 7'h6D, 4);
        add("single", 0, 1, 4'h1, 16'h0005, 4'h1, 4'h1, 7'h6D);
        add("single", 0, 1, 4'h1, 16'h0005, 4'h1, 4'h0, 7'h6D, 3);
        add("single", 0, 1, 4'h1, 16'h0005, 4'h1, 4'h1, 7'h6D);
        add("single", 0, 1, 4'h0, 16'h0005, 4'h0, 4'h0, 7'h00, 2);

        add("reset",  1, 1, 4'h0, 16'h0000, 4'h0, 4'h0, 7'h00);
        add("all",    0, 1, 4'hF, 16'hF3A0, 4'h1, 4'h0, 7'h3F, 4);
        add("all",    0, 1, 4'hF, 16'hF3A0, 4'h2, 4'h1, 7'h77);
        add("all",    0, 1, 4'hF, 16'hF3A0, 4'h2, 4'h0, 7'h77, 3);
        add("all",    0, 1, 4'hF, 16'hF3A0, 4'h4, 4'h2, 7'h4F);
        add("all",    0, 1, 4'hF, 16'hF3A0, 4'h4, 4'h0, 7'h4F, 3);
        add("all",    0, 1, 4'hF, 16'hF3A0, 4'h8, 4'h4, 7'h71);
        add("all",    0, 1, 4'hF, 16'hF3A0, 4'h8, 4'h0, 7'h71, 3);
        add("all",    0, 1, 4'hF, 16'hF3A0, 4'h1, 4'h8, 7'h3F);
        add("all",    0, 1, 4'h0, 16'hF3A0, 4'h0, 4'h0, 7'h00);

        add("reset",    1, 1, 4'h0, 16'h0000, 4'h0, 4'h0, 7'h00);
        add("withdraw", 0, 1, 4'h3, 16'h0021, 4'h1, 4'h0, 7'h06, 2);
        add("withdraw", 0, 1, 4'h2, 16'h0021, 4'h2, 4'h0, 7'h5B, 4);
        add("withdraw", 0, 1, 4'h2, 16'h0021, 4'h2, 4'h2, 7'h5B);
        add("withdraw", 0, 1, 4'h0, 16'h0021, 4'h0, 4'h0, 7'h00);

        add("reset",  1, 1, 4'h0, 16'h0000, 4'h0, 4'h0, 7'h00);
        add("freeze", 0, 1, 4'h1, 16'h0007, 4'h1, 4'h0, 7'h07, 2);
        add("freeze", 0, 0, 4'h1, 16'h0008, 4'h1, 4'h0, 7'h07, 10);
        add("freeze", 0, 1, 4'h1, 16'h0008, 4'h1, 4'h0, 7'h7F, 2);
        add("freeze", 0, 1, 4'h1, 16'h0008, 4'h1, 4'h1, 7'h7F);
        add("freeze", 0, 0, 4'h1, 16'h0008, 4'h1, 4'h0, 7'h7F);
        add("freeze", 0, 1, 4'h0, 16'h0008, 4'h0, 4'h0, 7'h00);

        add("midrst", 0, 1, 4'hF, 16'hF3A0, 4'h2, 4'h0, 7'h77, 2);
        add("midrst", 1, 1, 4'hF, 16'hF3A0, 4'h0, 4'h0, 7'h00);
        add("midrst", 0, 1, 4'hF, 16'hF3A0, 4'h1, 4'h0, 7'h3F);
        add("midrst", 1, 0, 4'hF, 16'hF3A0, 4'h0, 4'h0, 7'h00);
        add("midrst", 0, 1, 4'hF, 16'hF3A0, 4'h1, 4'h0, 7'h3F);
        add("midrst", 0, 1, 4'h0, 16'hF3A0, 4'h0, 4'h0, 7'h00);

        for (int j = 0; j < 16; j++)
            add("live", 0, 1, 4'h4, 16'(j << 8), 4'h4,
                (j == 4 || j == 8 || j == 12) ? 4'h4 : 4'h0, glyph[j]);
        add("live", 0, 1, 4'h4, 16'h0F00, 4'h4, 4'h4, 7'h71);
        add("live", 0, 1, 4'h0, 16'h0F00, 4'h0, 4'h0, 7'h00);

        add("reset", 1, 1, 4'h0, 16'h0000, 4'h0, 4'h0, 7'h00);

        $display("[TB] applying %0d vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

        // DWELL=1 instance: all requesting rotates every cycle with a done on each handover
        pat = 16'hF3A0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rst = 1'b0;
            en  = 1'b1;
            req = 4'hF;
            val = pat;
            @(posedge clk);
            #1;
            eg = 4'b0001 << (i % 4);
            ed = (i == 0) ? 4'h0 : 4'(4'b0001 << ((i - 1) % 4));
            es = glyph[pat[(i % 4) * 4 +: 4]];
            total++;
            if ({gnt1, done1, seg1, busy1} !== {eg, ed, es, 1'b1}) begin
                bad++;
                $display("[TB] FAIL dwell1 step %0d: got gnt=%b done=%b seg=%h busy=%b, want gnt=%b done=%b seg=%h busy=1",
                         i, gnt1, done1, seg1, busy1, eg, ed, es);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
